regfile_writeback: RTL

//  Write-side front end of RegisterFile: collects results from the ALU (single-cycle, no

---
 rtl/regfile_writeback_pkg.sv | 25 ++
 rtl/regfile_writeback_load_queue.sv | 74 +++++++
 rtl/regfile_writeback.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared constants and types for the register-file write-back front end.
package regfile_writeback_pkg;

    localparam int XLEN     = 32;
    localparam int NREG     = 32;
    localparam int AW       = $clog2(NREG);
    localparam int LQ_DEPTH = 2;

    // One result headed for the register file: destination and value.
    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_result_t;

    // Source chosen for the write port in a given cycle.
    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_ALU    = 2'd1,
        SEL_QUEUE  = 2'd2,
        SEL_BYPASS = 2'd3
    } wb_sel_e;

    localparam wb_result_t RES_ZERO = '{rd: {AW{1'b0}}, data: {XLEN{1'b0}}};

endpackage

// File: rtl/regfile_writeback_load_queue.sv
// Small synchronous FIFO holding load results that lost arbitration to the ALU.
module wb_load_queue
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = LQ_DEPTH
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  wb_result_t               push_data_i,
    input  logic                     pop_i,
    output wb_result_t               head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_nxt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    wb_result_t      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   rd_ptr_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            do_push_s;
    logic            do_pop_s;

    // Qualify push/pop against occupancy and compute next pointers and count.
    always_comb begin
        do_pop_s  = pop_i && (count_q != CNT_ZERO);
        do_push_s = push_i && ((count_q != CNT_FULL) || do_pop_s);
        wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = do_pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and storage registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RES_ZERO;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end else begin
                mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
            end
        end
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign empty_o     = (count_q == CNT_ZERO);
    assign count_nxt_o = count_d;

endmodule

// File: rtl/regfile_writeback.sv
// Write-side front end of the register file: arbitrates ALU and load results
// onto the single write port and tracks registers with loads in flight.
module regfile_writeback
    import regfile_writeback_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            iss_load,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            busy_rs1,
    output logic            busy_rs2,
    output logic            RegWrite,
    output logic [AW-1:0]   rd,
    output logic [XLEN-1:0] WriteData
);

    localparam int CW = $clog2(LQ_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(LQ_DEPTH);
    localparam logic [AW-1:0] REG_ZERO = {AW{1'b0}};

    wb_result_t      alu_res_s;
    wb_result_t      lsu_res_s;
    wb_result_t      head_s;
    wb_result_t      sel_res_s;
    wb_sel_e         sel_s;
    logic            lsu_acc_s;
    logic            q_push_s;
    logic            q_pop_s;
    logic            q_empty_s;
    logic [CW-1:0]   q_count_nxt_s;

    logic            lsu_ready_q;
    logic            lsu_ready_d;
    logic            reg_write_q;
    logic            reg_write_d;
    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   rd_d;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] wdata_d;
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    assign alu_res_s = '{rd: alu_rd, data: alu_data};
    assign lsu_res_s = '{rd: lsu_rd, data: lsu_data};

    wb_load_queue #(
        .DEPTH       (LQ_DEPTH)
    ) u_load_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (q_push_s),
        .push_data_i (lsu_res_s),
        .pop_i       (q_pop_s),
        .head_o      (head_s),
        .empty_o     (q_empty_s),
        .count_nxt_o (q_count_nxt_s)
    );

    // Arbitration: ALU first, then queued loads, then a direct load bypass.
    always_comb begin
        sel_s     = SEL_NONE;
        q_push_s  = 1'b0;
        q_pop_s   = 1'b0;
        lsu_acc_s = lsu_valid && lsu_ready_q;
        if (alu_valid) begin
            sel_s    = SEL_ALU;
            q_push_s = lsu_acc_s;
        end else if (!q_empty_s) begin
            sel_s    = SEL_QUEUE;
            q_pop_s  = 1'b1;
            q_push_s = lsu_acc_s;
        end else if (lsu_acc_s) begin
            sel_s    = SEL_BYPASS;
        end else begin
            sel_s    = SEL_NONE;
        end
    end

    // Result mux feeding the write-port registers.
    always_comb begin
        sel_res_s = RES_ZERO;
        case (sel_s)
            SEL_ALU:    sel_res_s = alu_res_s;
            SEL_QUEUE:  sel_res_s = head_s;
            SEL_BYPASS: sel_res_s = lsu_res_s;
            SEL_NONE:   sel_res_s = RES_ZERO;
            default:    sel_res_s = RES_ZERO;
        endcase
    end

    // Next write-port state; x0 results are consumed but never written.
    always_comb begin
        reg_write_d = (sel_s != SEL_NONE) && (sel_res_s.rd != REG_ZERO);
        rd_d        = (sel_s != SEL_NONE) ? sel_res_s.rd   : rd_q;
        wdata_d     = (sel_s != SEL_NONE) ? sel_res_s.data : wdata_q;
        lsu_ready_d = (q_count_nxt_s < CNT_FULL);
    end

    // Pending-load scoreboard: a selected load clears, a new issue sets (set wins).
    always_comb begin
        pending_d = pending_q;
        if ((sel_s == SEL_QUEUE) || (sel_s == SEL_BYPASS)) begin
            pending_d[sel_res_s.rd] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (iss_load && (iss_rd != REG_ZERO)) begin
            pending_d[iss_rd] = 1'b1;
        end else begin
            pending_d[0] = 1'b0;
        end
        pending_d[0] = 1'b0;
    end

    // Output, ready and scoreboard registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write_q <= 1'b0;
            rd_q        <= REG_ZERO;
            wdata_q     <= {XLEN{1'b0}};
            lsu_ready_q <= 1'b0;
            pending_q   <= {NREG{1'b0}};
        end else begin
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            lsu_ready_q <= lsu_ready_d;
            pending_q   <= pending_d;
        end
    end

    assign RegWrite  = reg_write_q;
    assign rd        = rd_q;
    assign WriteData = wdata_q;
    assign lsu_ready = lsu_ready_q;
    assign busy_rs1  = pending_q[rs1] && (rs1 != REG_ZERO);
    assign busy_rs2  = pending_q[rs2] && (rs2 != REG_ZERO);

endmodule
